// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared constants and helpers for the PmodI2S (CS4344) transmitter.
// Everything is derived from one 10-bit free-running divider on clk:
//   MCLK  = cnt[MCLK_BIT]   (clk/4)
//   SCLK  = cnt[SCLK_BIT]   (clk/16)
//   LRCLK = cnt[LRCLK_BIT]  (clk/1024)
// Each LRCLK half holds SLOT_BITS SCLK periods; the slot index is the bit field
// sitting directly between SCLK and LRCLK in the divider.
// -----------------------------------------------------------------------------
package i2s_pkg;

  localparam int CNT_W      = 10;
  localparam int MCLK_BIT   = 1;
  localparam int SCLK_BIT   = 3;
  localparam int LRCLK_BIT  = 9;
  localparam int SLOT_BITS  = 32;
  localparam int SLOT_W     = $clog2(SLOT_BITS);
  localparam int SLOT_LSB   = SCLK_BIT + 1;
  localparam int UNDERRUN_W = 16;

  localparam logic [CNT_W-1:0]      CNT_LAST     = '1;
  localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = '1;

  // LRCLK low carries the left channel, high the right channel.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // Slot index (SCLK period within the current channel) of a divider value.
  function automatic logic [SLOT_W-1:0] slot_of(input logic [CNT_W-1:0] c);
    return c[SLOT_LSB +: SLOT_W];
  endfunction

  // Channel selected by a divider value.
  function automatic chan_e chan_of(input logic [CNT_W-1:0] c);
    return chan_e'(c[LRCLK_BIT]);
  endfunction

endpackage

// File: rtl/i2s_if.sv
// -----------------------------------------------------------------------------
// i2s_if
// Sample handshake between a stereo sample producer and i2s_tx.
//   sample_l / sample_r : two's-complement pair offered by the producer
//   sample_valid        : producer offers a pair this cycle
//   sample_ready        : transmitter can take the pair this cycle
// A pair moves on any clk edge where sample_valid and sample_ready are both 1.
// Modports: master = sample producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface i2s_if #(
  parameter int SAMPLE_W = 16
) ();

  logic signed [SAMPLE_W-1:0] sample_l;
  logic signed [SAMPLE_W-1:0] sample_r;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_clkgen.sv
// -----------------------------------------------------------------------------
// i2s_clkgen
// Free-running 10-bit divider and registered I2S pin clocks.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   en        : run the divider; when low the divider and pins return to 0
//   cnt       : current divider value
//   slot_nxt  : slot index the divider moves to on the next edge
//   chan_nxt  : channel the divider moves to on the next edge
//   mclk, sclk, lrclk : pin clocks, registered copies of the divider bits
// The pin flops load the same next value as cnt, so each pin always equals
// its divider bit exactly and never glitches.  Nothing is clocked by them.
// -----------------------------------------------------------------------------
module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [CNT_W-1:0]  cnt,
  output logic [SLOT_W-1:0] slot_nxt,
  output chan_e             chan_nxt,
  output logic              mclk,
  output logic              sclk,
  output logic              lrclk
);

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (en) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  assign slot_nxt = slot_of(cnt_nxt);
  assign chan_nxt = chan_of(cnt_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      mclk  <= 1'b0;
      sclk  <= 1'b0;
      lrclk <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      mclk  <= cnt_nxt[MCLK_BIT];
      sclk  <= cnt_nxt[SCLK_BIT];
      lrclk <= cnt_nxt[LRCLK_BIT];
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
// Stereo I2S transmitter for the PmodI2S (CS4344), everything on clk.
// Ports:
//   clk, rst      : 100 MHz system clock, asynchronous active-high reset
//   en            : transmitter enable
//   smp           : i2s_if.slave sample handshake (one-entry holding buffer)
//   frame_start   : one-cycle pulse while the divider sits at 0 after a wrap
//   underrun_cnt  : frames started with an empty buffer, saturating at 0xFFFF
//   MCLK, LRCLK, SCLK, SDIN : PmodI2S pins
// Frame format: 32 SCLK periods per channel; period k carries sample bit
// (SAMPLE_W-k) for k=1..SAMPLE_W (MSB first, one SCLK late), 0 otherwise.
// The holding buffer is copied into the frame registers on the 1023->0 wrap;
// an empty buffer repeats the previous pair.
// -----------------------------------------------------------------------------
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  i2s_if.slave                  smp,
  output logic                  frame_start,
  output logic [UNDERRUN_W-1:0] underrun_cnt,
  output logic                  MCLK,
  output logic                  LRCLK,
  output logic                  SCLK,
  output logic                  SDIN
);

  logic [CNT_W-1:0]           cnt;
  logic [SLOT_W-1:0]          slot_nxt;
  chan_e                      chan_nxt;
  logic                       wrap;
  logic                       accept;

  logic                       buf_full;
  logic                       first_q;
  logic [UNDERRUN_W-1:0]      underrun_q;
  logic signed [SAMPLE_W-1:0] buf_l;
  logic signed [SAMPLE_W-1:0] buf_r;
  logic signed [SAMPLE_W-1:0] frm_l;
  logic signed [SAMPLE_W-1:0] frm_r;
  logic signed [SAMPLE_W-1:0] tx_word;
  logic                       sdin_q;

  // Bit carried in slot k of a channel: MSB in slot 1, zero padding around.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] word,
                                    input logic [SLOT_W-1:0]   k);
    logic [SAMPLE_W-1:0] sh;
    sh = word >> (SAMPLE_W - int'(k));
    if (k == '0 || int'(k) > SAMPLE_W) begin
      return 1'b0;
    end
    return sh[0];
  endfunction

  i2s_clkgen u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cnt      (cnt),
    .slot_nxt (slot_nxt),
    .chan_nxt (chan_nxt),
    .mclk     (MCLK),
    .sclk     (SCLK),
    .lrclk    (LRCLK)
  );

  assign wrap = en && (cnt == CNT_LAST);

  // rst is in the ready term because the async clear of buf_full would
  // otherwise raise sample_ready while reset is still asserted.
  assign smp.sample_ready = en && !buf_full && !rst;
  assign accept           = smp.sample_valid && smp.sample_ready;

  // Buffer occupancy, first-frame flag, underrun counter, frame_start.
  // On a wrap an empty buffer takes a pair accepted that same cycle straight
  // into the frame registers, so the buffer stays empty and it is no underrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full    <= 1'b0;
      first_q     <= 1'b1;
      underrun_q  <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (wrap) begin
        first_q <= 1'b0;
        if (buf_full) begin
          buf_full <= 1'b0;
        end else if (!accept && !first_q && underrun_q != UNDERRUN_MAX) begin
          underrun_q <= underrun_q + UNDERRUN_W'(1);
        end
      end else if (accept) begin
        buf_full <= 1'b1;
      end
    end
  end

  // Holding buffer data: contents only matter while buf_full is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_l <= smp.sample_l;
      buf_r <= smp.sample_r;
    end
  end

  // Frame registers: reload on wrap, otherwise hold (repeat on underrun).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_l <= '0;
      frm_r <= '0;
    end else if (wrap) begin
      if (buf_full) begin
        frm_l <= buf_l;
        frm_r <= buf_r;
      end else if (accept) begin
        frm_l <= smp.sample_l;
        frm_r <= smp.sample_r;
      end
    end
  end

  always_comb begin
    tx_word = frm_l;
    if (chan_nxt == CH_RIGHT) begin
      tx_word = frm_r;
    end
  end

  // SDIN is computed from the divider's next value, so it only moves when the
  // slot index moves (SCLK falling edge).  On a wrap the next slot is 0, whose
  // bit is always 0, so the frame register reload never shows up early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdin_q <= 1'b0;
    end else begin
      sdin_q <= slot_bit(tx_word, slot_nxt);
    end
  end

  assign SDIN         = sdin_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter SAMPLE_W, default 16: sample width in bits; legal range 8..31.
REQ-002 Port clk, input, 1: 100 MHz system clock; all logic on posedge clk.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port en, input, 1: transmitter enable.
REQ-005 Port sample_l, input, SAMPLE_W: left channel sample, two's complement.
REQ-006 Port sample_r, input, SAMPLE_W: right channel sample, two's complement.
REQ-007 Port sample_valid, input, 1: sample_l/sample_r pair offered.
REQ-008 Port sample_ready, output, 1: holding buffer can accept a pair.
REQ-009 Port frame_start, output, 1: one-cycle pulse when a new frame begins.
REQ-010 Port underrun_cnt, output, 16: count of frames started with an empty buffer; saturates at 0xFFFF.
REQ-011 Ports MCLK, LRCLK, SCLK, SDIN, output, 1 each: PmodI2S (CS4344) pins.

Function
REQ-012 A 10-bit free-running divider cnt SHALL increment each clk while en=1 and wrap 1023->0.
REQ-013 MCLK SHALL equal cnt[1] (clk/4, 25 MHz); SCLK SHALL equal cnt[3] (clk/16); LRCLK SHALL equal cnt[9] (clk/1024, ~97.66 kHz); all registered, glitch-free.
REQ-014 LRCLK=0 SHALL denote left channel, LRCLK=1 right; 32 SCLK periods per channel, index k=cnt[8:4].
REQ-015 SDIN during period k of a channel SHALL carry bit (SAMPLE_W-k) for k=1..SAMPLE_W (MSB first, one-SCLK I2S delay) and 0 for k=0 and k>SAMPLE_W.
REQ-016 SDIN SHALL change only on SCLK falling edges, i.e. in the clk cycle after cnt[3:0]=15.
REQ-017 Holding buffer: one entry; sample_ready=1 iff buffer empty and en=1; a pair is accepted on any cycle with sample_valid=1 and sample_ready=1.
REQ-018 On the cycle cnt=1023->0 the buffer SHALL be copied to the frame shift registers, emptied, and frame_start pulsed for the cycle cnt=0.
REQ-019 Acceptance and frame load on the same cycle: the buffered pair is transmitted, the new pair is not accepted (sample_ready was 0); accept-while-empty on the load cycle loads the new pair directly.
REQ-020 Empty buffer at frame start: previous frame pair SHALL be repeated and underrun_cnt incremented (saturating).
REQ-021 Latency: pair accepted while cnt=c appears on SDIN starting 1024-c+16 clk later (left MSB period k=1).
REQ-022 en=0: cnt cleared to 0, MCLK/LRCLK/SCLK/SDIN driven 0, sample_ready=0, frame_start=0; buffer and underrun_cnt held; en rising restarts at cnt=0 with frame load on the first 1023->0 wrap.

Reset
REQ-023 rst=1 SHALL immediately clear cnt, buffer (empty), frame registers (zero), underrun_cnt, and drive sample_ready, frame_start, MCLK, LRCLK, SCLK, SDIN to 0.
REQ-024 Reset mid-frame SHALL abort the frame; after release first frame transmits zeros unless a pair is accepted beforehand.
REQ-025 The first frame after reset with empty buffer SHALL NOT count as underrun.

Structure
REQ-026 Shared package i2s_pkg SHALL hold divider bit positions (MCLK_BIT=1, SCLK_BIT=3, LRCLK_BIT=9), CNT_W=10, SLOT_BITS=32.
REQ-027 Divider and pin clock generation SHALL be one sub-module, i2s_clkgen, exporting cnt and the three pin clocks.
REQ-028 No derived clocks SHALL clock logic inside the block; everything runs on clk.

Verification
REQ-029 Reset: assert rst mid-frame -> all outputs 0 within same cycle; release -> MCLK period 4, SCLK 16, LRCLK 1024 clk.
REQ-030 Pattern: push L=0xA5C3, R=0x0F0F -> SDIN decodes 1010010111000011 in left periods 1..16, 0000111100001111 in right, zeros elsewhere.
REQ-031 Backpressure: hold sample_valid=1 with two pairs queued -> sample_ready low until cnt=0 load; second pair sent next frame.
REQ-032 Underrun: one pair then no valid for 3 frames -> same pair repeated 3 times, underrun_cnt=3.
REQ-033 Enable: drop en at cnt=500 -> pins 0, cnt 0; raise -> LRCLK first rises 512 clk later, frame_start 1024 clk later.
REQ-034 Saturation: force 65540 underrun frames -> underrun_cnt holds 0xFFFF.
